// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter, 8N1 framing; optional even parity bit when UART_TX_PARITY_EN is defined
module uart_tx #(
    parameter int BAUD_END = 5207,
    parameter int BIT_END  = 8
) (
    input  logic       sclk,
    input  logic       s_rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_trig,
    output logic       rs232_tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int BAUD_W = (BAUD_END > 0) ? $clog2(BAUD_END + 1) : 1;
    localparam int BIT_W  = (BIT_END > 1) ? $clog2(BIT_END) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [BAUD_W-1:0]  baud_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [7:0]         tx_shift;
    logic               line_next;
    logic               shift_en;
    logic               accept;
    logic               baud_end;
    logic               bit_last;
`ifdef UART_TX_PARITY_EN
    logic               parity_bit;
`endif

    assign baud_end = (baud_cnt == BAUD_W'(BAUD_END));
    assign bit_last = (bit_cnt == BIT_W'(BIT_END - 1));
    assign accept   = (state == IDLE) && tx_trig;
    assign tx_busy  = (state != IDLE);

    // Next state and next line level; the line is only ever updated on bit boundaries
    always_comb begin
        next_state = state;
        line_next  = rs232_tx;
        shift_en   = 1'b0;
        case (state)
            IDLE: begin
                line_next = 1'b1;
                if (tx_trig) begin
                    next_state = START;
                    line_next  = 1'b0;
                end
            end
            START: begin
                if (baud_end) begin
                    next_state = DATA;
                    line_next  = tx_shift[0];
                    shift_en   = 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    if (bit_last) begin
`ifdef UART_TX_PARITY_EN
                        next_state = PARITY;
                        line_next  = parity_bit;
`else
                        next_state = STOP;
                        line_next  = 1'b1;
`endif
                    end else begin
                        line_next = tx_shift[0];
                        shift_en  = 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_end) begin
                    next_state = STOP;
                    line_next  = 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_end) begin
                    next_state = IDLE;
                    line_next  = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
                line_next  = 1'b1;
            end
        endcase
    end

    // State register, registered line output and the one-cycle completion pulse
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state    <= IDLE;
            rs232_tx <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            state    <= next_state;
            rs232_tx <= line_next;
            tx_done  <= (state == STOP) && baud_end;
        end
    end

    // Bit-period and data-bit counters; both sit at zero while idle
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            if (state == IDLE || baud_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
            if (state != DATA) begin
                bit_cnt <= '0;
            end else if (baud_end) begin
                bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
            end
        end
    end

    // Byte is captured only on an accepted trigger, then shifted out LSB first
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            tx_shift <= '0;
        end else if (accept) begin
            tx_shift <= tx_data;
        end else if (shift_en) begin
            tx_shift <= {1'b0, tx_shift[7:1]};
        end
    end

`ifdef UART_TX_PARITY_EN
    // Even parity over the captured byte, fixed for the whole frame
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            parity_bit <= 1'b0;
        end else if (accept) begin
            parity_bit <= ^tx_data;
        end
    end
`endif

endmodule
